// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scanout: timing counters, 4x-replicated framebuffer addressing
// and a fixed 3-cycle pipeline keeping pixel, sync and frame markers aligned.
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_WIDTH    = H_ACTIVE >> SCALE_SHIFT,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_on,
  output logic                  frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;

  // Raster position; the line counter advances on each horizontal wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + CW'(1);
    end else begin
      h_count <= h_count + CW'(1);
    end
  end

  logic                  act0_c;
  logic                  hs0_c;
  logic                  vs0_c;
  logic                  fs0_c;
  logic [ADDR_WIDTH-1:0] addr0_c;

  // Stage 0 decode of the current raster position
  always_comb begin
    act0_c  = (h_count < H_ACT) && (v_count < V_ACT);
    hs0_c   = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    vs0_c   = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
    fs0_c   = act0_c && (h_count == '0) && (v_count == '0);
    addr0_c = '0;
    if (act0_c) begin
      addr0_c = ADDR_WIDTH'(32'(v_count >> SCALE_SHIFT) * FB_WIDTH
                            + 32'(h_count >> SCALE_SHIFT));
    end
  end

  logic act1, hs1, vs1, fs1;
  logic act2, hs2, vs2, fs2;

  // Stages 1-3; reset loads inactive values so nothing stale leaks out afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      read_addr   <= '0;
      act1        <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      fs1         <= 1'b0;
      act2        <= 1'b0;
      hs2         <= 1'b1;
      vs2         <= 1'b1;
      fs2         <= 1'b0;
      pixel       <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      read_addr   <= addr0_c;
      act1        <= act0_c;
      hs1         <= hs0_c;
      vs1         <= vs0_c;
      fs1         <= fs0_c;
      act2        <= act1;
      hs2         <= hs1;
      vs2         <= vs1;
      fs2         <= fs1;
      pixel       <= act2 ? q : '0;
      video_on    <= act2;
      hsync       <= hs2;
      vsync       <= vs2;
      frame_start <= fs2;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: full-size and shrunken-geometry instances against an
// arithmetic raster model, with queued expectations and sync/frame measurements.
module tb_vga_fb_scanout;

  localparam int unsigned AW = 15;

  typedef struct packed {
    int unsigned ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
  } geo_t;

  typedef struct packed {
    int unsigned   h;
    int unsigned   v;
    logic [AW-1:0] addr;
    logic          pix;
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
  } exp_t;

  localparam geo_t GD = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geo_t GS = '{40, 4, 8, 4, 24, 2, 2, 3};
  localparam int unsigned HT_S    = 40 + 4 + 8 + 4;
  localparam int unsigned FRAME_S = HT_S * (24 + 2 + 2 + 3);
  localparam int unsigned MID_POS = 15 * HT_S + 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ra_d, ra_s;
  logic [0:0]    q_d, q_s, pix_d, pix_s;
  logic          hs_d, vs_d, von_d, fs_d;
  logic          hs_s, vs_s, von_s, fs_s;

  vga_fb_scanout dut_d (
    .clk(clk), .reset(reset), .read_addr(ra_d), .q(q_d), .pixel(pix_d),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .frame_start(fs_d)
  );

  vga_fb_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3), .FB_WIDTH(10)
  ) dut_s (
    .clk(clk), .reset(reset), .read_addr(ra_s), .q(q_s), .pixel(pix_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s), .frame_start(fs_s)
  );

  // Framebuffer models with a registered one-cycle read
  logic mem_d [32768];
  logic mem_s [32768];
  always @(posedge clk) begin
    q_d <= mem_d[ra_d];
    q_s <= mem_s[ra_s];
  end

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h required 0x%0h", name, $time, got, req);
    end
  endfunction

  function automatic void missing(string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t: got empty queue required an expected entry", name, $time);
  endfunction

  // Raster model: n-th pixel slot since reset release, from the timing rules
  function automatic exp_t model(geo_t g, int unsigned n);
    exp_t e;
    int unsigned ht, vt, h, v;
    ht = g.ha + g.hfp + g.hsy + g.hbp;
    vt = g.va + g.vfp + g.vsy + g.vbp;
    h = n % ht;
    v = (n / ht) % vt;
    e.h    = h;
    e.v    = v;
    e.act  = (h < g.ha) && (v < g.va);
    e.hs   = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsy));
    e.vs   = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsy));
    e.addr = e.act ? AW'((v / 4) * (g.ha / 4) + h / 4) : '0;
    e.fs   = e.act && (h == 0) && (v == 0);
    e.pix  = 1'b0;
    return e;
  endfunction

  exp_t qa_d[$], qo_d[$], qa_s[$], qo_s[$];
  int unsigned issued = 0;

  // Issue side: one pixel slot per clock, expectations queued for the monitor
  always @(posedge clk) begin : drv
    exp_t e;
    if (reset) begin
      qa_d.delete(); qo_d.delete(); qa_s.delete(); qo_s.delete();
      issued = 0;
    end else begin
      e = model(GD, issued);
      e.pix = e.act & mem_d[e.addr];
      qa_d.push_back(e);
      qo_d.push_back(e);
      e = model(GS, issued);
      e.pix = e.act & mem_s[e.addr];
      qa_s.push_back(e);
      qo_s.push_back(e);
      issued++;
    end
  end

  int unsigned mk = 0;
  int unsigned cyc = 0;
  int unsigned t_rise, t_hfall, t_fs, t_vfall;
  logic have_rise, have_hfall, have_fs, have_vfall;
  logic von_prev, hs_prev, vs_prev;

  // Monitor: samples 3 time units after each rising edge
  always begin : mon
    logic r;
    exp_t ed, es;
    @(posedge clk);
    r = reset;
    #3;
    cyc++;
    if (r) begin
      check("rst_d", 64'({ra_d, pix_d, hs_d, vs_d, von_d, fs_d}), 64'({AW'(0), 5'b01100}));
      check("rst_s", 64'({ra_s, pix_s, hs_s, vs_s, von_s, fs_s}), 64'({AW'(0), 5'b01100}));
      mk = 0;
      have_rise = 1'b0; have_hfall = 1'b0; have_fs = 1'b0; have_vfall = 1'b0;
      von_prev = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
    end else begin
      mk++;
      if (qa_d.size() == 0 || qa_s.size() == 0) begin
        missing("addr_queue");
      end else begin
        ed = qa_d.pop_front();
        es = qa_s.pop_front();
        check("addr_d", 64'(ra_d), 64'(ed.addr));
        check("addr_s", 64'(ra_s), 64'(es.addr));
        if (ed.h == 4 && ed.v == 0)   check("addr_4_0", 64'(ra_d), 64'd1);
        if (ed.h == 3 && ed.v == 0)   check("addr_3_0", 64'(ra_d), 64'd0);
        if (ed.h == 0 && ed.v == 4)   check("addr_0_4", 64'(ra_d), 64'd160);
        if (ed.h == 700 && ed.v == 1) check("addr_blank", 64'(ra_d), 64'd0);
        if (es.h == 39 && es.v == 23) check("addr_max_s", 64'(ra_s), 64'd59);
      end
      if (mk < 3) begin
        check("fill_d", 64'({pix_d, hs_d, vs_d, von_d, fs_d}), 64'(5'b01100));
        check("fill_s", 64'({pix_s, hs_s, vs_s, von_s, fs_s}), 64'(5'b01100));
      end else if (qo_d.size() == 0 || qo_s.size() == 0) begin
        missing("out_queue");
      end else begin
        ed = qo_d.pop_front();
        es = qo_s.pop_front();
        check("out_d", 64'({pix_d, von_d, hs_d, vs_d, fs_d}),
              64'({ed.pix, ed.act, ed.hs, ed.vs, ed.fs}));
        check("out_s", 64'({pix_s, von_s, hs_s, vs_s, fs_s}),
              64'({es.pix, es.act, es.hs, es.vs, es.fs}));
        if (ed.v < 4 && ed.h < 8)
          check("pix_replic", 64'(pix_d), (ed.h < 4) ? 64'd1 : 64'd0);
      end
      if (mk == 3) check("first_px", 64'({von_d, fs_d, von_s, fs_s}), 64'(4'b1111));
      if (mk == 4) check("fs_pulse", 64'({fs_d, fs_s}), 64'(2'b00));

      // Horizontal sync placement on the full-size raster
      if (von_d && !von_prev) begin
        t_rise = cyc;
        have_rise = 1'b1;
      end
      if (!hs_d && hs_prev && have_rise) begin
        check("hs_offset", 64'(cyc - t_rise), 64'd656);
        t_hfall = cyc;
        have_hfall = 1'b1;
      end
      if (hs_d && !hs_prev && have_hfall) check("hs_width", 64'(cyc - t_hfall), 64'd96);

      // Frame period and vertical sync on the shrunken raster
      if (fs_s) begin
        if (have_fs) check("frame_period", 64'(cyc - t_fs), 64'(FRAME_S));
        t_fs = cyc;
        have_fs = 1'b1;
      end
      if (!vs_s && vs_prev && have_fs) begin
        check("vs_offset", 64'(cyc - t_fs), 64'((24 + 2) * HT_S));
        t_vfall = cyc;
        have_vfall = 1'b1;
      end
      if (vs_s && !vs_prev && have_vfall) check("vs_width", 64'(cyc - t_vfall), 64'(2 * HT_S));

      von_prev = von_d;
      hs_prev  = hs_d;
      vs_prev  = vs_s;
    end
  end

  initial begin
    bit found;
    foreach (mem_d[i]) mem_d[i] = 1'($urandom);
    foreach (mem_s[i]) mem_s[i] = 1'($urandom);
    mem_d[0] = 1'b1;
    mem_d[1] = 1'b0;

    reset = 1'b1;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4300) @(posedge clk);

    // Single-cycle reset while the shrunken raster sits at (30,15)
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_S && !found; i++) begin
      @(posedge clk);
      #2;
      if (issued % FRAME_S == MID_POS) found = 1'b1;
    end
    if (!found) begin
      missing("midframe_position");
    end else begin
      reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
    end
    repeat (3600) @(posedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Read-side consumer of the dual-port framebuffer. It generates 640x480@60 VGA timing on the pixel clock, which is the framebuffer read clock. It drives framebuffer read addresses with 4x pixel replication, so a 160x120 1-bit image fills the screen. Returned data is aligned with registered hsync/vsync/video_on outputs for the DAC/pin stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SCALE_SHIFT, 2, log2 of pixel replication factor
FB_WIDTH, 160, framebuffer row stride in pixels (H_ACTIVE>>SCALE_SHIFT)
ADDR_WIDTH, 15, framebuffer address width
DATA_WIDTH, 1, framebuffer data width

Ports:
clk  in  1  pixel clock; also the framebuffer read_clock
reset  in  1  synchronous, active-high
read_addr  out  ADDR_WIDTH  framebuffer read address, registered
q  in  DATA_WIDTH  framebuffer read data; registered inside the RAM, valid 1 cycle after read_addr
pixel  out  DATA_WIDTH  pixel value, forced 0 outside the active area
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
video_on  out  1  high when pixel is in the visible area
frame_start  out  1  one-cycle pulse coincident with output of pixel (0,0)

Behaviour:
- Reset is synchronous and active-high, using one clock, clk. While reset is high:
  - h_count=0, v_count=0, read_addr=0, pixel=0, hsync=1, vsync=1, video_on=0, frame_start=0.
  - All delay-pipeline stages load inactive values.
- Counters:
  - h_count runs 0..H_TOTAL-1, with H_TOTAL = sum of the H params = 800. It wraps to 0.
  - v_count increments only when h_count wraps. It runs 0..V_TOTAL-1 (525) and wraps to 0.
  - Counter widths are 10 bits.
- Stage 0 (cycle n): counters hold (h,v). Define:
  - act = (h<H_ACTIVE)&&(v<V_ACTIVE)
  - hs_n = !(H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC), i.e. low for h 656..751
  - vs_n = !(V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC), i.e. low for v 490..491
- Stage 1 (cycle n+1):
  - read_addr = (v>>SCALE_SHIFT)*FB_WIDTH + (h>>SCALE_SHIFT), truncated to ADDR_WIDTH, when act; otherwise 0.
  - Multiply uses a constant stride. The maximum address is 119*160+159 = 19199, which fits in 15 bits.
  - act, hs_n and vs_n are delayed alongside.
- Stage 2 (cycle n+2): framebuffer presents q for that address. Sync/act are delayed one more stage.
- Stage 3 (cycle n+3): outputs register:
  - pixel = act ? q : 0
  - video_on = act
  - hsync = hs_n, vsync = vs_n
  - frame_start = act && h==0 && v==0 (delayed)
- Fixed latency: counter state to all outputs is 3 cycles. All four outputs stay mutually aligned; no skew between sync and pixel is permitted.
- No stalls and no handshake: the framebuffer read port is read every active cycle. Writes on the other port are never blocked. A same-address write/read collision returns whatever the RAM returns; no special handling.
- Frame period = 800*525 = 420000 cycles. frame_start pulses exactly once per frame.
- Reset mid-frame: on the next cycle, counters return to (0,0) and outputs go to their reset values. The pipeline is flushed, so no stale pixel or sync pulse emerges after reset deasserts.
- The first output pixel (0,0) appears with video_on=1 on the 3rd clock after reset deasserts.

Test Plan:
- Reset release: hold reset 5 cycles, then release. Required:
  - hsync=vsync=1, video_on=0 during reset.
  - video_on=1 and frame_start=1 exactly 3 cycles after release, frame_start low on the next cycle.
- Address mapping: model RAM with 1-cycle read. Required:
  - counter (4,0) gives read_addr=1.
  - (3,0) gives 0.
  - (0,4) gives 160.
  - (639,479) gives 19199.
  - any blanking position gives 0.
- Pixel path: preload RAM addr 0 = 1, addr 1 = 0. Required:
  - pixel=1 for output columns 0..3 of lines 0..3.
  - pixel=0 for columns 4..7.
  - pixel=0 whenever video_on=0, even if RAM addr 0 = 1.
- Sync timing: per line, hsync low for exactly 96 cycles, starting 656 cycles after video_on rises. vsync low for exactly 2*800 cycles, starting at line 490.
- Frame period: measure between consecutive frame_start pulses. Required: exactly 420000 cycles, across 2 frames.
- Reset mid-frame: assert reset for 1 cycle at counter (300,200). Required: outputs return to reset values the next cycle, and frame_start occurs exactly 3 cycles after deassertion.
